// File: rtl/video_dma.sv
// video_dma: programmable VRAM copy/fill engine.
// Sits in front of the video block's CPU-side VRAM port and multiplexes CPU
// accesses with its own DMA traffic. The CPU always wins the port; the DMA
// simply holds its state on any cycle where cpu_vram_sel is high.
//
// Ports:
//   clk, reset_n                  system clock, async active-low reset
//   io_addr/io_wrdata/io_wren     register write port (8 registers)
//   io_rddata                     combinational register readback
//   cpu_vram_*                    CPU VRAM request; cpu_vram_rddata is a passthrough
//   vram_addr/wrdata/wren         muxed request to the video VRAM port
//   vram_rddata                   VRAM read data, one cycle after the address
//   vblank                        vblank level, used for start gating
//   irq                           done & irq_en
//
// Register map: 0/1 SRC, 2/3 DST, 4/5 LEN (lo/hi), 6 FILL, 7 CTRL/STAT.
module video_dma (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  io_addr,
  output logic [7:0]  io_rddata,
  input  logic [7:0]  io_wrdata,
  input  logic        io_wren,
  input  logic        cpu_vram_sel,
  input  logic [13:0] cpu_vram_addr,
  input  logic [7:0]  cpu_vram_wrdata,
  input  logic        cpu_vram_wren,
  output logic [7:0]  cpu_vram_rddata,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wrdata,
  output logic        vram_wren,
  input  logic [7:0]  vram_rddata,
  input  logic        vblank,
  output logic        irq
);

  // Completion does not occupy a state of its own: the last granted access
  // sets done and returns straight to IDLE, so done is visible the cycle
  // after the final write.
  typedef enum logic [2:0] {
    S_IDLE, S_WAITVB, S_ENTRY, S_FILL, S_READ, S_WRITE
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [7:0]  fill_q, fill_d, byte_q, byte_d;
  logic        mode_q, mode_d, wait_vb_q, wait_vb_d, irq_en_q, irq_en_d;
  logic        done_q, done_d, vblank_q, vblank_d, wr_first_q, wr_first_d;

  logic        busy, grant, ctrl_wr, abort;
  logic [13:0] dma_addr;
  logic [7:0]  dma_wrdata;
  logic        dma_wren;
  logic [1:0]  unused_wrdata;

  assign busy          = (state_q != S_IDLE);
  assign grant         = ~cpu_vram_sel;
  assign ctrl_wr       = io_wren && (io_addr == 3'd7);
  assign abort         = ctrl_wr && io_wrdata[6] && busy;
  assign unused_wrdata = io_wrdata[5:4];

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    fill_d     = fill_q;
    byte_d     = byte_q;
    mode_d     = mode_q;
    wait_vb_d  = wait_vb_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    vblank_d   = vblank;
    wr_first_d = 1'b0;
    dma_addr   = 14'd0;
    dma_wrdata = 8'd0;
    dma_wren   = 1'b0;

    // Clear comes first so that a same-cycle completion overrides it.
    if (ctrl_wr && io_wrdata[7]) done_d = 1'b0;

    if (io_wren && !busy) begin
      case (io_addr)
        3'd0: src_d[7:0]  = io_wrdata;
        3'd1: src_d[13:8] = io_wrdata[5:0];
        3'd2: dst_d[7:0]  = io_wrdata;
        3'd3: dst_d[13:8] = io_wrdata[5:0];
        3'd4: len_d[7:0]  = io_wrdata;
        3'd5: len_d[13:8] = io_wrdata[5:0];
        3'd6: fill_d      = io_wrdata;
        default: begin
          mode_d    = io_wrdata[1];
          wait_vb_d = io_wrdata[2];
          irq_en_d  = io_wrdata[3];
          if (io_wrdata[0]) begin
            done_d  = 1'b0;
            state_d = io_wrdata[2] ? S_WAITVB : S_ENTRY;
          end
        end
      endcase
    end

    case (state_q)
      S_WAITVB: if (vblank && !vblank_q) state_d = S_ENTRY;
      S_ENTRY: begin
        if (len_q == 14'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = mode_q ? S_FILL : S_READ;
        end
      end
      S_FILL: begin
        dma_addr   = dst_q;
        dma_wrdata = fill_q;
        dma_wren   = 1'b1;
        if (grant) begin
          dst_d = dst_q + 14'd1;
          len_d = len_q - 14'd1;
          if (len_q == 14'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_READ: begin
        dma_addr = src_q;
        if (grant) begin
          src_d      = src_q + 14'd1;
          state_d    = S_WRITE;
          wr_first_d = 1'b1;
        end
      end
      S_WRITE: begin
        // Read data is only on vram_rddata in the first WRITE cycle; a CPU
        // access in that cycle would otherwise lose it, so keep a copy.
        dma_addr   = dst_q;
        dma_wrdata = wr_first_q ? vram_rddata : byte_q;
        dma_wren   = 1'b1;
        if (wr_first_q) byte_d = vram_rddata;
        if (grant) begin
          dst_d = dst_q + 14'd1;
          len_d = len_q - 14'd1;
          if (len_q == 14'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end
      default: ;
    endcase

    // Abort freezes the pointers where they are; any write granted this
    // cycle still reaches the port since the mux below is unaffected.
    if (abort) begin
      state_d    = S_IDLE;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      done_d     = 1'b0;
      wr_first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_q      <= 14'd0;
      dst_q      <= 14'd0;
      len_q      <= 14'd0;
      fill_q     <= 8'd0;
      byte_q     <= 8'd0;
      mode_q     <= 1'b0;
      wait_vb_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      vblank_q   <= 1'b0;
      wr_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      byte_q     <= byte_d;
      mode_q     <= mode_d;
      wait_vb_q  <= wait_vb_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      vblank_q   <= vblank_d;
      wr_first_q <= wr_first_d;
    end
  end

  assign vram_addr       = cpu_vram_sel ? cpu_vram_addr   : dma_addr;
  assign vram_wrdata     = cpu_vram_sel ? cpu_vram_wrdata : dma_wrdata;
  assign vram_wren       = cpu_vram_sel ? cpu_vram_wren   : dma_wren;
  assign cpu_vram_rddata = vram_rddata;
  assign irq             = done_q & irq_en_q;

  always_comb begin
    case (io_addr)
      3'd0:    io_rddata = src_q[7:0];
      3'd1:    io_rddata = {2'b00, src_q[13:8]};
      3'd2:    io_rddata = dst_q[7:0];
      3'd3:    io_rddata = {2'b00, dst_q[13:8]};
      3'd4:    io_rddata = len_q[7:0];
      3'd5:    io_rddata = {2'b00, len_q[13:8]};
      3'd6:    io_rddata = fill_q;
      default: io_rddata = {done_q, 3'b000, irq_en_q, wait_vb_q, mode_q, busy};
    endcase
  end

endmodule
